fft_frame_sequencer: RTL and testbench

Sequences fixed-length sample frames from the audio input FIFO (show-ahead read port, `fft_clk` domain) into the forward FFT sink. It drives a correct Avalon-ST valid/ready handshake with SOP/EOP framing and never starts a frame until a whole frame is buffered. It also captures the block exponent reported by the FFT source for downstream scaling. It replaces the ad-hoc fill logic around `fft_in`, and it owns `fifo rdreq` and all `sink_*` controls.

---
 rtl/fft_seq_pkg.sv | 14 +
 rtl/fft_seq_stats.sv | 33 +++
 rtl/fft_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_fft_frame_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: state encoding and
// default frame/exponent sizes used by the sequencer and its stats block.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } seq_state_t;

    localparam int SAMPLES_DEF = 8192;
    localparam int EXP_W_DEF   = 6;

endpackage

// File: rtl/fft_seq_stats.sv
// Statistics counters for the FFT frame sequencer.
// frame_count wraps; stall_count saturates at all-ones.
module fft_seq_stats (
    input  logic        fft_clk,
    input  logic        reset_n,
    input  logic        eop_xfer_i,
    input  logic        stall_i,
    output logic [15:0] frame_count_o,
    output logic [15:0] stall_count_o
);

    logic [15:0] frame_q;
    logic [15:0] stall_q;

    // Count completed frames (wrapping) and backpressure cycles (saturating).
    always_ff @(posedge fft_clk) begin
        if (!reset_n) begin
            frame_q <= '0;
            stall_q <= '0;
        end else begin
            if (eop_xfer_i) begin
                frame_q <= frame_q + 16'd1;
            end
            if (stall_i && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign frame_count_o = frame_q;
    assign stall_count_o = stall_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Sequences fixed-length frames from a show-ahead FIFO into an Avalon-ST
// FFT sink and captures the FFT block exponent.
// Optional statistics counters are built when FFT_SEQ_STATS_EN is defined;
// otherwise frame_count/stall_count read as zero.
//
// Handshake: a sample transfers on any cycle where sink_valid && sink_ready.
// sink_valid, framing and data hold while sink_ready is low; fifo_rdreq is
// exactly the transfer term so the FIFO pops on the same edge.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int CNT_W   = 16,
    parameter int DATA_W  = 16,
    parameter int EXP_W   = EXP_W_DEF
) (
    input  logic              fft_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  fifo_rdusedw,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic [EXP_W-1:0]  source_exp,
    output logic [EXP_W-1:0]  exp_out,
    output logic              exp_valid,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic [15:0]       stall_count,
    output seq_state_t        dbg_state
);

    localparam logic [CNT_W-1:0] SAMPLES_C = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(SAMPLES - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [EXP_W-1:0] exp_q;
    logic             exp_valid_q;
    logic             xfer;

    // State and sample index registers.
    always_ff @(posedge fft_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: start only with a whole frame buffered; stream until the
    // last sample transfers, then one GAP cycle back to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (fifo_rdusedw >= SAMPLES_C)) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (idx_q == LAST_C) begin
                        state_d = ST_GAP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state and index; data passes straight from FIFO.
    always_comb begin
        sink_valid = (state_q == ST_STREAM);
        sink_sop   = (state_q == ST_STREAM) && (idx_q == '0);
        sink_eop   = (state_q == ST_STREAM) && (idx_q == LAST_C);
        busy       = (state_q == ST_STREAM) || (state_q == ST_GAP);
        xfer       = sink_valid && sink_ready;
        fifo_rdreq = xfer;
        sink_real  = fifo_q;
        dbg_state  = state_q;
    end

    // Exponent capture on source SOP, independent of the sequencer state.
    always_ff @(posedge fft_clk) begin
        if (!reset_n) begin
            exp_q       <= '0;
            exp_valid_q <= 1'b0;
        end else begin
            exp_valid_q <= source_valid && source_sop;
            if (source_valid && source_sop) begin
                exp_q <= source_exp;
            end
        end
    end

    assign exp_out   = exp_q;
    assign exp_valid = exp_valid_q;

`ifdef FFT_SEQ_STATS_EN
    logic eop_xfer;
    logic stall;

    assign eop_xfer = xfer && sink_eop;
    assign stall    = sink_valid && !sink_ready;

    fft_seq_stats u_stats (
        .fft_clk       (fft_clk),
        .reset_n       (reset_n),
        .eop_xfer_i    (eop_xfer),
        .stall_i       (stall),
        .frame_count_o (frame_count),
        .stall_count_o (stall_count)
    );
`else
    assign frame_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a 16-sample frame.
// Stats expectations follow FFT_SEQ_STATS_EN: counts when defined, zero when not.
module tb_fft_frame_sequencer;

    localparam int SAMPLES = 16;
    localparam int CNT_W   = 16;
    localparam int DATA_W  = 16;
    localparam int EXP_W   = 6;
`ifdef FFT_SEQ_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              fft_clk;
    logic              reset_n;
    logic              enable;
    logic [CNT_W-1:0]  fifo_rdusedw;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rdreq;
    logic              sink_ready;
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic [DATA_W-1:0] sink_real;
    logic              source_valid;
    logic              source_sop;
    logic [EXP_W-1:0]  source_exp;
    logic [EXP_W-1:0]  exp_out;
    logic              exp_valid;
    logic              busy;
    logic [15:0]       frame_count;
    logic [15:0]       stall_count;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_stalls = 0;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  fill;

    assign fifo_q       = head;
    assign fifo_rdusedw = fill;

    fft_frame_sequencer #(
        .SAMPLES (SAMPLES),
        .CNT_W   (CNT_W),
        .DATA_W  (DATA_W),
        .EXP_W   (EXP_W)
    ) dut (
        .fft_clk      (fft_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_rdusedw (fifo_rdusedw),
        .fifo_q       (fifo_q),
        .fifo_rdreq   (fifo_rdreq),
        .sink_ready   (sink_ready),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_exp   (source_exp),
        .exp_out      (exp_out),
        .exp_valid    (exp_valid),
        .busy         (busy),
        .frame_count  (frame_count),
        .stall_count  (stall_count),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial fft_clk = 1'b0;
    always #5 fft_clk = ~fft_clk;

    // Advance one cycle; the FIFO model pops when rdreq is high before the edge.
    task automatic tick();
        logic pop;
        #1;
        pop = fifo_rdreq;
        @(posedge fft_clk);
        #1;
        if (pop) begin
            head = head + 16'd1;
            fill = fill - 16'd1;
        end
    endtask

    // Wait (bounded) for the next SOP.
    task automatic wait_sop(input string tag);
        int n;
        n = 0;
        while (!sink_sop && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!sink_sop) begin
            errors++;
            $display("FAIL %s_sop_timeout: sink_sop=%0b after %0d cycles, required 1", tag, sink_sop, n);
        end
    endtask

    // Drive one frame starting at SOP, with optional stall and enable drop.
    task automatic xfer_frame(input int stall_at, input int stall_len, input int drop_at, input string tag);
        for (int i = 0; i < SAMPLES; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i == stall_at) begin
                sink_ready = 1'b0;
                #1;
                for (int s = 0; s < stall_len; s++) begin
                    checks++;
                    if (sink_valid !== 1'b1 || fifo_rdreq !== 1'b0 || sink_sop !== (i == 0) ||
                        sink_eop !== (i == SAMPLES-1) || sink_real !== exp_data) begin
                        errors++;
                        $display("FAIL %s_stall_hold i=%0d s=%0d: valid=%0b rdreq=%0b sop=%0b eop=%0b data=%h, required 1 0 %0b %0b %h",
                                 tag, i, s, sink_valid, fifo_rdreq, sink_sop, sink_eop, sink_real,
                                 (i == 0), (i == SAMPLES-1), exp_data);
                    end
                    tick();
                    exp_stalls++;
                end
                sink_ready = 1'b1;
                #1;
            end
            checks++;
            if (sink_valid !== 1'b1 || fifo_rdreq !== 1'b1 || sink_sop !== (i == 0) ||
                sink_eop !== (i == SAMPLES-1) || sink_real !== exp_data) begin
                errors++;
                $display("FAIL %s_xfer i=%0d: valid=%0b rdreq=%0b sop=%0b eop=%0b data=%h, required 1 1 %0b %0b %h",
                         tag, i, sink_valid, fifo_rdreq, sink_sop, sink_eop, sink_real,
                         (i == 0), (i == SAMPLES-1), exp_data);
            end
            tick();
            exp_data = exp_data + 16'd1;
        end
        exp_frames++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (sink_valid !== 1'b0 || sink_sop !== 1'b0 || sink_eop !== 1'b0 || fifo_rdreq !== 1'b0 ||
            busy !== 1'b0 || exp_valid !== 1'b0 || exp_out !== 6'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b sop=%0b eop=%0b rdreq=%0b busy=%0b expv=%0b exp=%h st=%0d, required all 0",
                     sink_valid, sink_sop, sink_eop, fifo_rdreq, busy, exp_valid, exp_out, dbg_state);
        end
        checks++;
        if (frame_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: frame=%0d stall=%0d, required 0 0", frame_count, stall_count);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_threshold();
        fill = 16'd15;
        enable = 1'b1;
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sink_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL threshold_15 c=%0d: valid=%0b busy=%0b, required 0 0", i, sink_valid, busy);
            end
        end
        fill = 16'd16;
        tick();
        checks++;
        if (sink_valid !== 1'b1 || sink_sop !== 1'b1) begin
            errors++;
            $display("FAIL threshold_16_start: valid=%0b sop=%0b, required 1 1", sink_valid, sink_sop);
        end
        xfer_frame(-1, 0, -1, "threshold");
        checks++;
        if (sink_valid !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL threshold_gap: valid=%0b busy=%0b st=%0d, required 0 1 2", sink_valid, busy, dbg_state);
        end
        checks++;
        if (frame_count !== (STATS_ON ? 16'(exp_frames) : 16'd0)) begin
            errors++;
            $display("FAIL threshold_frame_count: %0d, required %0d", frame_count, STATS_ON ? exp_frames : 0);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL threshold_idle: busy=%0b st=%0d, required 0 0", busy, dbg_state);
        end
    endtask

    task automatic test_backpressure();
        fill = 16'd16;
        wait_sop("bp");
        xfer_frame(5, 3, -1, "bp");
        checks++;
        if (stall_count !== (STATS_ON ? 16'(exp_stalls) : 16'd0) || exp_stalls != 3) begin
            errors++;
            $display("FAIL bp_stall_count: %0d, required %0d", stall_count, STATS_ON ? 3 : 0);
        end
        checks++;
        if (sink_valid !== 1'b0 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL bp_end_after_16: valid=%0b st=%0d, required 0 2", sink_valid, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        fill = 16'd32;
        wait_sop("b2b");
        xfer_frame(-1, 0, -1, "b2b_first");
        // After the EOP edge: GAP, IDLE, then SOP.
        checks++;
        if (sink_valid !== 1'b0 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL b2b_gap: valid=%0b st=%0d, required 0 2", sink_valid, dbg_state);
        end
        tick();
        checks++;
        if (sink_valid !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL b2b_idle: valid=%0b st=%0d, required 0 0", sink_valid, dbg_state);
        end
        tick();
        checks++;
        if (sink_valid !== 1'b1 || sink_sop !== 1'b1) begin
            errors++;
            $display("FAIL b2b_next_sop: valid=%0b sop=%0b, required 1 1", sink_valid, sink_sop);
        end
        xfer_frame(-1, 0, -1, "b2b_second");
        checks++;
        if (frame_count !== (STATS_ON ? 16'(exp_frames) : 16'd0)) begin
            errors++;
            $display("FAIL b2b_frame_count: %0d, required %0d", frame_count, STATS_ON ? exp_frames : 0);
        end
    endtask

    task automatic test_enable_drop();
        fill = 16'd56;
        wait_sop("en");
        xfer_frame(-1, 0, 8, "en");
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (sink_valid !== 1'b0 || fifo_rdreq !== 1'b0 || fill !== 16'd40) begin
                errors++;
                $display("FAIL en_stay_idle c=%0d: valid=%0b rdreq=%0b fill=%0d, required 0 0 40",
                         i, sink_valid, fifo_rdreq, fill);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        enable = 1'b1;
        wait_sop("rst");
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_data = exp_data + 16'd1;
        end
        reset_n = 1'b0;
        tick();
        // The idx-10 sample was still popped on the reset edge.
        exp_data = exp_data + 16'd1;
        checks++;
        if (sink_valid !== 1'b0 || sink_sop !== 1'b0 || sink_eop !== 1'b0 || fifo_rdreq !== 1'b0 ||
            busy !== 1'b0 || frame_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%0b sop=%0b eop=%0b rdreq=%0b busy=%0b frame=%0d stall=%0d, required all 0",
                     sink_valid, sink_sop, sink_eop, fifo_rdreq, busy, frame_count, stall_count);
        end
        exp_frames = 0;
        exp_stalls = 0;
        reset_n = 1'b1;
        wait_sop("rst_restart");
        xfer_frame(-1, 0, -1, "rst_restart");
        checks++;
        if (frame_count !== (STATS_ON ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL rst_restart_frame_count: %0d, required %0d", frame_count, STATS_ON ? 1 : 0);
        end
        tick();
    endtask

    task automatic test_exponent();
        enable = 1'b0;
        source_valid = 1'b1;
        source_sop = 1'b1;
        source_exp = 6'b111101;
        tick();
        source_valid = 1'b0;
        source_sop = 1'b0;
        source_exp = 6'd5;
        checks++;
        if (exp_valid !== 1'b1 || exp_out !== 6'b111101) begin
            errors++;
            $display("FAIL exp_capture: valid=%0b exp=%b, required 1 111101", exp_valid, exp_out);
        end
        tick();
        checks++;
        if (exp_valid !== 1'b0 || exp_out !== 6'b111101) begin
            errors++;
            $display("FAIL exp_pulse_end: valid=%0b exp=%b, required 0 111101", exp_valid, exp_out);
        end
        source_sop = 1'b1;
        tick();
        checks++;
        if (exp_valid !== 1'b0 || exp_out !== 6'b111101) begin
            errors++;
            $display("FAIL exp_sop_no_valid: valid=%0b exp=%b, required 0 111101", exp_valid, exp_out);
        end
        source_sop = 1'b0;
        source_valid = 1'b1;
        tick();
        checks++;
        if (exp_valid !== 1'b0 || exp_out !== 6'b111101) begin
            errors++;
            $display("FAIL exp_valid_no_sop: valid=%0b exp=%b, required 0 111101", exp_valid, exp_out);
        end
        source_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        sink_ready = 1'b1;
        source_valid = 1'b0;
        source_sop = 1'b0;
        source_exp = '0;
        head = 16'h0100;
        exp_data = 16'h0100;
        fill = '0;
        test_reset();
        test_threshold();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        test_exponent();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
